// File: rtl/ctrl_pkg.sv
// Shared control-unit definitions: sequencer state encoding and phase constants.
// The named phase encodings are reused by the downstream p1..p5 phase decode.
package ctrl_pkg;

  localparam int NUM_PHASES = 5;
  localparam int PHASE_W    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } seq_state_e;

  localparam logic [PHASE_W-1:0] PH_0 = 3'd0;
  localparam logic [PHASE_W-1:0] PH_1 = 3'd1;
  localparam logic [PHASE_W-1:0] PH_2 = 3'd2;
  localparam logic [PHASE_W-1:0] PH_3 = 3'd3;
  localparam logic [PHASE_W-1:0] PH_4 = 3'd4;

endpackage

// File: rtl/exec_debouncer.sv
// Cleans the raw exec pushbutton: 2-flop synchronizer, stability counter and
// a registered one-cycle pulse on each debounced rising edge.
module exec_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic exec,
  output logic exec_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_pulse;

  // Synchronize, then only accept a new level after it has held for the full window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], exec};
      r_pulse <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_pulse <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign exec_pulse = r_pulse;

endmodule

// File: rtl/phase_sequencer.sv
// Phase-clock sequencer: produces the phase index and run/stop state for the
// control unit, with free-run, single-step and halt-at-boundary modes.
module phase_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_PHASES      = ctrl_pkg::NUM_PHASES,
  parameter int PHASE_W         = ctrl_pkg::PHASE_W,
  parameter int COUNT_W         = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               exec,
  input  logic               step_mode,
  input  logic               halt,
  output logic [PHASE_W-1:0] phase,
  output logic               running,
  output logic               halted,
  output logic               exec_pulse,
  output logic [COUNT_W-1:0] instr_count
);

  import ctrl_pkg::*;

  logic               w_exec_pulse;
  logic               w_last;
  seq_state_e         r_state;
  logic [PHASE_W-1:0] r_phase;
  logic               r_running;
  logic               r_halted;
  logic               r_stop_req;
  logic [COUNT_W-1:0] r_instr_count;

  exec_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_exec_debouncer (
    .clock     (clock),
    .reset     (reset),
    .exec      (exec),
    .exec_pulse(w_exec_pulse)
  );

  assign w_last = (r_phase == PHASE_W'(NUM_PHASES - 1));

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_phase       <= '0;
      r_running     <= 1'b0;
      r_halted      <= 1'b0;
      r_stop_req    <= 1'b0;
      r_instr_count <= '0;
    end else begin
      // The exit cycle still counts: running is high while the last phase is shown.
      if (r_running && w_last) begin
        r_instr_count <= r_instr_count + COUNT_W'(1);
      end
      case (r_state)
        IDLE: begin
          r_phase <= '0;
          if (w_exec_pulse) begin
            r_state   <= step_mode ? STEP : RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (w_last) begin
            r_phase <= '0;
            if (halt) begin
              r_state    <= HALTED;
              r_running  <= 1'b0;
              r_halted   <= 1'b1;
              r_stop_req <= 1'b0;
            end else if (r_stop_req || w_exec_pulse) begin
              r_state    <= IDLE;
              r_running  <= 1'b0;
              r_stop_req <= 1'b0;
            end
          end else begin
            r_phase <= r_phase + PHASE_W'(1);
            if (w_exec_pulse) begin
              r_stop_req <= 1'b1;
            end
          end
        end
        STEP: begin
          if (w_last) begin
            r_phase    <= '0;
            r_running  <= 1'b0;
            r_stop_req <= 1'b0;
            if (halt) begin
              r_state  <= HALTED;
              r_halted <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_phase <= r_phase + PHASE_W'(1);
          end
        end
        HALTED: begin
          r_phase   <= '0;
          r_running <= 1'b0;
          r_halted  <= 1'b1;
        end
        default: begin
          r_state    <= IDLE;
          r_phase    <= '0;
          r_running  <= 1'b0;
          r_halted   <= 1'b0;
          r_stop_req <= 1'b0;
        end
      endcase
    end
  end

  assign phase       = r_phase;
  assign running     = r_running;
  assign halted      = r_halted;
  assign exec_pulse  = w_exec_pulse;
  assign instr_count = r_instr_count;

endmodule
